// File: rtl/operand_decode_stage.sv
// operand_decode_stage: decode-to-execute operand stage.
//   Extends the raw immediate, selects each source operand from the EX/MEM
//   forwarding paths or the register file, and registers the result in a
//   one-entry valid/ready output register. A two-state hazard FSM inserts a
//   single bubble on a load-use dependency against the EX stage.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready              upstream handshake (in_ready combinational)
//   imm_off, imm_zext                raw immediate and extension mode
//   rs1/rs2_addr, rs1/rs2_rdata      source indices and register-file data
//   ex_wr_en/rd_addr/rd_data/is_load EX-stage writeback and load flag
//   mem_wr_en/rd_addr/rd_data        MEM-stage writeback
//   flush                            kill held and incoming instruction
//   out_valid / out_ready            downstream handshake
//   extd_imm_off, alu_rs1/rs2_data   registered payload
//   load_use_stall                   combinational load-use bubble indicator
module operand_decode_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm_off,
  input  logic              imm_zext,
  input  logic [RA_W-1:0]   rs1_addr,
  input  logic [RA_W-1:0]   rs2_addr,
  input  logic [DATA_W-1:0] rs1_rdata,
  input  logic [DATA_W-1:0] rs2_rdata,
  input  logic              ex_wr_en,
  input  logic [RA_W-1:0]   ex_rd_addr,
  input  logic [DATA_W-1:0] ex_rd_data,
  input  logic              ex_is_load,
  input  logic              mem_wr_en,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] extd_imm_off,
  output logic [DATA_W-1:0] alu_rs1_data,
  output logic [DATA_W-1:0] alu_rs2_data,
  output logic              load_use_stall
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0] rs2_q, rs2_d;

  logic              imm_fill;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic              ex_load_hit;
  logic              out_free;
  logic              capture;

  // Immediate extension; fill bit is 0 for zero-extend, sign bit otherwise.
  assign imm_fill = !imm_zext && imm_off[IMM_W-1];

  if (IMM_W == DATA_W) begin : g_imm_pass
    assign imm_ext = imm_off;
  end else begin : g_imm_ext
    localparam int unsigned EXT_W = DATA_W - IMM_W;
    assign imm_ext = {{EXT_W{imm_fill}}, imm_off};
  end

  // Operand 1 forwarding: EX non-load result wins over MEM, then register file.
  always_comb begin
    rs1_fwd = rs1_rdata;
    if (ex_wr_en && !ex_is_load && (ex_rd_addr == rs1_addr)) begin
      rs1_fwd = ex_rd_data;
    end else if (mem_wr_en && (mem_rd_addr == rs1_addr)) begin
      rs1_fwd = mem_rd_data;
    end
  end

  // Operand 2 forwarding, independent of operand 1.
  always_comb begin
    rs2_fwd = rs2_rdata;
    if (ex_wr_en && !ex_is_load && (ex_rd_addr == rs2_addr)) begin
      rs2_fwd = ex_rd_data;
    end else if (mem_wr_en && (mem_rd_addr == rs2_addr)) begin
      rs2_fwd = mem_rd_data;
    end
  end

  // Load in EX targets a source we need; only meaningful while in RUN.
  assign ex_load_hit = ex_wr_en && ex_is_load &&
                       ((ex_rd_addr == rs1_addr) || (ex_rd_addr == rs2_addr));

  assign load_use_stall = (state_q == RUN) && in_valid && ex_load_hit;
  assign out_free       = !out_valid_q || out_ready;
  assign in_ready       = out_free && !load_use_stall;
  // flush does not gate in_ready, but it does block the capture itself.
  assign capture        = in_valid && in_ready && !flush;

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use_stall && out_free) begin
            // Insert the bubble; the load result reaches MEM next cycle.
            state_d     = BUBBLE;
            out_valid_d = 1'b0;
          end else if (capture) begin
            out_valid_d = 1'b1;
            imm_d       = imm_ext;
            rs1_d       = rs1_fwd;
            rs2_d       = rs2_fwd;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        BUBBLE: begin
          state_d = RUN;
          if (capture) begin
            out_valid_d = 1'b1;
            imm_d       = imm_ext;
            rs1_d       = rs1_fwd;
            rs2_d       = rs2_fwd;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = RUN;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign extd_imm_off = imm_q;
  assign alu_rs1_data = rs1_q;
  assign alu_rs2_data = rs2_q;

endmodule

// File: tb/tb_operand_decode_stage.sv
// tb_operand_decode_stage: directed bench with an expected-result queue for
// operand_decode_stage at DATA_W=16, IMM_W=8, RA_W=3.
module tb_operand_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  imm_off;
  logic        imm_zext;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] rs1_rdata, rs2_rdata;
  logic        ex_wr_en;
  logic [2:0]  ex_rd_addr;
  logic [15:0] ex_rd_data;
  logic        ex_is_load;
  logic        mem_wr_en;
  logic [2:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] extd_imm_off;
  logic [15:0] alu_rs1_data, alu_rs2_data;
  logic        load_use_stall;

  typedef struct packed {
    logic [15:0] imm;
    logic [15:0] rs1;
    logic [15:0] rs2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  operand_decode_stage #(.DATA_W(16), .IMM_W(8), .RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_off(imm_off), .imm_zext(imm_zext),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .ex_wr_en(ex_wr_en), .ex_rd_addr(ex_rd_addr),
    .ex_rd_data(ex_rd_data), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .extd_imm_off(extd_imm_off),
    .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the payload against the oldest expected entry; retire it if asked.
  task automatic check_out(input string tag, input bit retire);
    exp_t e;
    chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb[0];
      chk1({tag, "_out_valid"}, out_valid, 1'b1);
      chk16({tag, "_imm"}, extd_imm_off, e.imm);
      chk16({tag, "_rs1"}, alu_rs1_data, e.rs1);
      chk16({tag, "_rs2"}, alu_rs2_data, e.rs2);
      if (retire) void'(sb.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    imm_off     = '0;
    imm_zext    = 1'b0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rs1_rdata   = '0;
    rs2_rdata   = '0;
    ex_wr_en    = 1'b0;
    ex_rd_addr  = '0;
    ex_rd_data  = '0;
    ex_is_load  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_addr = '0;
    mem_rd_data = '0;
    flush       = 1'b0;
  endtask

  task automatic set_src(input logic [2:0] a1, input logic [15:0] d1,
                         input logic [2:0] a2, input logic [15:0] d2);
    rs1_addr  = a1;
    rs1_rdata = d1;
    rs2_addr  = a2;
    rs2_rdata = d2;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_imm", extd_imm_off, 16'h0000);
    chk16("rst_rs1", alu_rs1_data, 16'h0000);
    chk16("rst_rs2", alu_rs2_data, 16'h0000);
    chk1("rst_stall", load_use_stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Immediate sign- and zero-extension, back to back.
    in_valid = 1'b1;
    imm_off  = 8'h9C;
    imm_zext = 1'b0;
    set_src(3'd1, 16'hA1A1, 3'd2, 16'hB2B2);
    #1 chk1("sext_in_ready", in_ready, 1'b1);
    sb.push_back('{imm: 16'hFF9C, rs1: 16'hA1A1, rs2: 16'hB2B2});
    step();
    check_out("sext", 1'b1);
    imm_zext = 1'b1;
    sb.push_back('{imm: 16'h009C, rs1: 16'hA1A1, rs2: 16'hB2B2});
    step();
    check_out("zext", 1'b1);
    in_valid = 1'b0;
    step();
    chk1("drain_out_valid", out_valid, 1'b0);

    // Forwarding priority: EX over MEM over register file.
    in_valid    = 1'b1;
    imm_off     = 8'h05;
    imm_zext    = 1'b0;
    set_src(3'd3, 16'h3333, 3'd4, 16'h4444);
    ex_wr_en    = 1'b1;
    ex_is_load  = 1'b0;
    ex_rd_addr  = 3'd3;
    ex_rd_data  = 16'h1111;
    mem_wr_en   = 1'b1;
    mem_rd_addr = 3'd3;
    mem_rd_data = 16'h2222;
    sb.push_back('{imm: 16'h0005, rs1: 16'h1111, rs2: 16'h4444});
    step();
    check_out("fwd_ex", 1'b1);
    ex_wr_en = 1'b0;
    sb.push_back('{imm: 16'h0005, rs1: 16'h2222, rs2: 16'h4444});
    step();
    check_out("fwd_mem", 1'b1);
    // Same register on both operands, EX and MEM both matching.
    set_src(3'd3, 16'h3333, 3'd3, 16'h5555);
    ex_wr_en = 1'b1;
    sb.push_back('{imm: 16'h0005, rs1: 16'h1111, rs2: 16'h1111});
    step();
    check_out("fwd_same", 1'b1);
    idle_inputs();
    step();
    chk1("fwd_drain", out_valid, 1'b0);

    // Load-use: one stall cycle, one bubble, then MEM forwarding.
    in_valid   = 1'b1;
    imm_off    = 8'h7F;
    set_src(3'd1, 16'h0101, 3'd5, 16'h0000);
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd_addr = 3'd5;
    ex_rd_data = 16'hDEAD;
    #1;
    chk1("lu_stall", load_use_stall, 1'b1);
    chk1("lu_in_ready", in_ready, 1'b0);
    step();
    chk1("lu_bubble", out_valid, 1'b0);
    // EX still shows the load: the bubble state must ignore it.
    mem_wr_en   = 1'b1;
    mem_rd_addr = 3'd5;
    mem_rd_data = 16'hBEEF;
    #1;
    chk1("lu_stall_clear", load_use_stall, 1'b0);
    chk1("lu_in_ready2", in_ready, 1'b1);
    sb.push_back('{imm: 16'h007F, rs1: 16'h0101, rs2: 16'hBEEF});
    step();
    idle_inputs();
    check_out("lu_fwd", 1'b1);
    step();

    // Backpressure: hold for three cycles, then back-to-back transfers.
    in_valid = 1'b1;
    imm_off  = 8'h01;
    imm_zext = 1'b1;
    set_src(3'd1, 16'h1010, 3'd2, 16'h2020);
    sb.push_back('{imm: 16'h0001, rs1: 16'h1010, rs2: 16'h2020});
    step();
    check_out("bp_a", 1'b0);
    out_ready = 1'b0;
    imm_off   = 8'h02;
    set_src(3'd1, 16'h3030, 3'd2, 16'h4040);
    for (int i = 0; i < 3; i++) begin
      #1 chk1("bp_in_ready_low", in_ready, 1'b0);
      step();
      check_out("bp_hold", 1'b0);
    end
    out_ready = 1'b1;
    #1 chk1("bp_in_ready_high", in_ready, 1'b1);
    void'(sb.pop_front());
    sb.push_back('{imm: 16'h0002, rs1: 16'h3030, rs2: 16'h4040});
    step();
    check_out("bp_b", 1'b1);
    imm_off = 8'h03;
    set_src(3'd6, 16'h6006, 3'd7, 16'h7007);
    sb.push_back('{imm: 16'h0003, rs1: 16'h6006, rs2: 16'h7007});
    step();
    check_out("bp_c", 1'b1);
    in_valid = 1'b0;
    step();
    chk1("bp_drain", out_valid, 1'b0);

    // Flush with a held instruction and a new one arriving.
    in_valid = 1'b1;
    imm_off  = 8'h04;
    imm_zext = 1'b0;
    set_src(3'd1, 16'h5050, 3'd2, 16'h6060);
    sb.push_back('{imm: 16'h0004, rs1: 16'h5050, rs2: 16'h6060});
    step();
    check_out("fl_d", 1'b1);
    flush   = 1'b1;
    imm_off = 8'h55;
    set_src(3'd1, 16'h7777, 3'd2, 16'h8888);
    #1 chk1("fl_in_ready", in_ready, 1'b1);
    step();
    flush = 1'b0;
    chk1("fl_out_valid", out_valid, 1'b0);
    chk16("fl_imm_kept", extd_imm_off, 16'h0004);
    chk16("fl_rs1_kept", alu_rs1_data, 16'h5050);
    // Flush while in the bubble state.
    set_src(3'd1, 16'h1212, 3'd5, 16'h3434);
    ex_wr_en   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd_addr = 3'd5;
    #1 chk1("flb_stall", load_use_stall, 1'b1);
    step();
    chk1("flb_bubble", out_valid, 1'b0);
    flush = 1'b1;
    #1 chk1("flb_stall_off", load_use_stall, 1'b0);
    step();
    flush = 1'b0;
    chk1("flb_out_valid", out_valid, 1'b0);
    chk16("flb_rs2_kept", alu_rs2_data, 16'h6060);
    #1 chk1("flb_run", load_use_stall, 1'b1);
    idle_inputs();
    step();

    // Asynchronous reset while holding, then a clean transfer.
    in_valid = 1'b1;
    imm_off  = 8'h80;
    imm_zext = 1'b0;
    set_src(3'd1, 16'h1234, 3'd2, 16'h5678);
    sb.push_back('{imm: 16'hFF80, rs1: 16'h1234, rs2: 16'h5678});
    step();
    check_out("rh_g", 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check_out("rh_hold", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rh_out_valid", out_valid, 1'b0);
    chk16("rh_imm", extd_imm_off, 16'h0000);
    chk16("rh_rs1", alu_rs1_data, 16'h0000);
    chk16("rh_rs2", alu_rs2_data, 16'h0000);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    imm_off   = 8'h12;
    imm_zext  = 1'b1;
    set_src(3'd1, 16'h0A0A, 3'd2, 16'h0B0B);
    #1 chk1("rh_in_ready", in_ready, 1'b1);
    sb.push_back('{imm: 16'h0012, rs1: 16'h0A0A, rs2: 16'h0B0B});
    step();
    check_out("rh_h", 1'b1);
    in_valid = 1'b0;
    step();
    chk1("rh_drain", out_valid, 1'b0);
    chk1("sb_empty", sb.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_decode_stage.md
OPERAND_DECODE_STAGE -- requirements
Module: operand_decode_stage

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- DATA_W, 16: operand and immediate output width.
- IMM_W, 8: raw immediate width; legal range 2..DATA_W.
- RA_W, 3: register address width.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock; rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  decoded instruction fields present.
- in_ready  out  1  stage accepts the fields this cycle.
- imm_off  in  IMM_W  raw immediate/offset.
- imm_zext  in  1  1 = zero-extend, 0 = sign-extend.
- rs1_addr, rs2_addr  in  RA_W  source register indices.
- rs1_rdata, rs2_rdata  in  DATA_W  register-file read data.
- ex_wr_en  in  1  EX-stage instruction writes a register.
- ex_rd_addr  in  RA_W  EX destination index.
- ex_rd_data  in  DATA_W  EX ALU result.
- ex_is_load  in  1  EX instruction is a load; data not yet available.
- mem_wr_en  in  1  MEM-stage instruction writes a register.
- mem_rd_addr  in  RA_W  MEM destination index.
- mem_rd_data  in  DATA_W  MEM result.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- extd_imm_off  out  DATA_W  extended immediate, registered.
- alu_rs1_data, alu_rs2_data  out  DATA_W  forwarded operands, registered.
- load_use_stall  out  1  load-use bubble active, combinational.

Function
REQ-003 SHALL hold a one-entry output register; latency = 1 cycle from accepted input to out_valid.
REQ-004 SHALL capture only on a transfer: capture = in_valid && in_ready.
- in_ready = (!out_valid || out_ready) && !load_use_stall.
REQ-005 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-006 SHALL clear out_valid on the next edge when out_ready=1 and no capture occurs.
REQ-007 SHALL select each operand with priority:
- first, EX match: ex_wr_en && !ex_is_load && ex_rd_addr == rsN_addr;
- then, MEM match: mem_wr_en && mem_rd_addr == rsN_addr;
- otherwise rsN_rdata.
REQ-008 SHALL extend the immediate as follows:
- imm_zext=1: zero-fill the upper DATA_W-IMM_W bits.
- imm_zext=0: replicate imm_off[IMM_W-1] into the upper bits.
- IMM_W == DATA_W: pass imm_off through unchanged.
REQ-009 SHALL implement hazard FSM states RUN and BUBBLE.
REQ-010 In RUN, load_use_stall = in_valid && ex_wr_en && ex_is_load && ex_rd_addr matches rs1_addr or rs2_addr.
REQ-011 RUN SHALL go to BUBBLE on the edge where load_use_stall=1 and the output register is free (!out_valid || out_ready).
- The output register is written with out_valid=0 on that edge.
REQ-012 BUBBLE SHALL force load_use_stall=0, suppress the EX load-match check, and return to RUN on the next edge.
- The loaded value then arrives on the MEM forwarding path.
REQ-013 flush SHALL take priority over capture, stall and hold:
- next edge: out_valid=0, FSM=RUN, data registers unchanged;
- in_ready is not gated by flush, but no capture takes effect while flush=1.
REQ-014 SHALL treat simultaneous EX and MEM matches on the same register per REQ-007, with EX winning.
REQ-015 SHALL forward independently per operand; rs1_addr == rs2_addr is legal, and both operands then get the same forwarded value.
REQ-016 SHALL contain no combinational path from out_ready to any data output.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force:
- out_valid=0;
- extd_imm_off, alu_rs1_data, alu_rs2_data = 0;
- FSM=RUN.
REQ-018 SHALL, on reset assertion mid-stall or mid-hold, discard the held instruction; the first capture after release behaves as from idle.

Verification
REQ-019 Bench SHALL cover these scenarios (defaults, DATA_W=16, IMM_W=8):
- Sign-extend: imm_off=8'h9C, imm_zext=0 -> extd_imm_off=16'hFF9C one cycle later; with imm_zext=1 -> 16'h009C.
- Forward priority: rs1_addr=3; EX writes r3 with 16'h1111 (non-load); MEM writes r3 with 16'h2222; rs1_rdata=16'h3333 -> alu_rs1_data=16'h1111. Removing the EX match -> 16'h2222.
- Load-use: EX load to r5; in_valid with rs2_addr=5 -> load_use_stall=1 and in_ready=0 for exactly one cycle, one out_valid=0 bubble. Next cycle MEM r5=16'hBEEF -> alu_rs2_data=16'hBEEF.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0. Then out_ready=1 with a new in_valid -> back-to-back transfer, no loss or duplication.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no capture. Flush during BUBBLE -> FSM=RUN.
- Reset: rst_n driven low asynchronously mid-hold -> all outputs 0 immediately; after release, one transfer gives correct data.
